// File: rtl/rgb_wheel_pwm.sv
// RGB colour-wheel PWM generator for the iCE40 SB_RGBA_DRV.
// Walks a saturated 6-phase hue wheel, scales it and emits 8-bit PWM.
module rgb_wheel_pwm #(
   parameter int STEP_CYCLES = 23437
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] brightness,
   output logic       r,
   output logic       g,
   output logic       b,
   output logic [2:0] phase
);

   localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(STEP_CYCLES - 1);

   typedef enum logic [2:0] {
      P0 = 3'd0,
      P1 = 3'd1,
      P2 = 3'd2,
      P3 = 3'd3,
      P4 = 3'd4,
      P5 = 3'd5
   } phase_t;

   logic [7:0]    pwm_cnt;
   logic [PW-1:0] pre_cnt;
   logic [7:0]    ramp;
   phase_t        phase_q;
   phase_t        phase_d;
   logic          step_tick;
   logic          ramp_top;

   logic [7:0] lvl_r;
   logic [7:0] lvl_g;
   logic [7:0] lvl_b;
   logic [7:0] fall;
   logic [8:0] bsc;
   logic [7:0] scl_r;
   logic [7:0] scl_g;
   logic [7:0] scl_b;
   logic [7:0] duty_r;
   logic [7:0] duty_g;
   logic [7:0] duty_b;

   assign step_tick = en && (pre_cnt == PRE_LAST);
   assign ramp_top  = (ramp == 8'hff);
   assign fall      = ~ramp;
   assign phase     = phase_q;

   // free-running PWM counter, independent of en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= 8'd0;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
      end
   end

   // step prescaler, frozen while en is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (en) begin
         if (step_tick) begin
            pre_cnt <= '0;
         end else begin
            pre_cnt <= pre_cnt + PW'(1);
         end
      end
   end

   // ramp position inside the current phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ramp <= 8'd0;
      end else if (step_tick) begin
         ramp <= ramp + 8'd1;
      end
   end

   // wheel phase state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= P0;
      end else begin
         phase_q <= phase_d;
      end
   end

   // next phase and per-phase colour levels; codes 6/7 fall back to P0
   always_comb begin
      phase_d = phase_q;
      lvl_r   = 8'hff;
      lvl_g   = ramp;
      lvl_b   = 8'h00;
      case (phase_q)
         P0: begin
            lvl_r = 8'hff;
            lvl_g = ramp;
            lvl_b = 8'h00;
            if (step_tick && ramp_top) phase_d = P1;
         end
         P1: begin
            lvl_r = fall;
            lvl_g = 8'hff;
            lvl_b = 8'h00;
            if (step_tick && ramp_top) phase_d = P2;
         end
         P2: begin
            lvl_r = 8'h00;
            lvl_g = 8'hff;
            lvl_b = ramp;
            if (step_tick && ramp_top) phase_d = P3;
         end
         P3: begin
            lvl_r = 8'h00;
            lvl_g = fall;
            lvl_b = 8'hff;
            if (step_tick && ramp_top) phase_d = P4;
         end
         P4: begin
            lvl_r = ramp;
            lvl_g = 8'h00;
            lvl_b = 8'hff;
            if (step_tick && ramp_top) phase_d = P5;
         end
         P5: begin
            lvl_r = 8'hff;
            lvl_g = 8'h00;
            lvl_b = fall;
            if (step_tick && ramp_top) phase_d = P0;
         end
         default: begin
            lvl_r = 8'hff;
            lvl_g = ramp;
            lvl_b = 8'h00;
            if (step_tick) phase_d = P0;
         end
      endcase
   end

   // brightness scale: level * (brightness + 1) / 256
   always_comb begin
      bsc   = {1'b0, brightness} + 9'd1;
      scl_r = 8'((17'(lvl_r) * 17'(bsc)) >> 8);
      scl_g = 8'((17'(lvl_g) * 17'(bsc)) >> 8);
      scl_b = 8'((17'(lvl_b) * 17'(bsc)) >> 8);
   end

   // duty shadows load only at the period wrap so a period never glitches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_r <= 8'd0;
         duty_g <= 8'd0;
         duty_b <= 8'd0;
      end else if (pwm_cnt == 8'hff) begin
         duty_r <= scl_r;
         duty_g <= scl_g;
         duty_b <= scl_b;
      end
   end

   // registered PWM compare, gated by en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r <= 1'b0;
         g <= 1'b0;
         b <= 1'b0;
      end else begin
         r <= en && (pwm_cnt < duty_r);
         g <= en && (pwm_cnt < duty_g);
         b <= en && (pwm_cnt < duty_b);
      end
   end

endmodule

// File: tb/tb_rgb_wheel_pwm.sv
// Bench for rgb_wheel_pwm with a fast step rate.
// Reference model feeds a scoreboard; directed checks cover wheel timing.
module tb_rgb_wheel_pwm;

   localparam int STEP = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [7:0] brightness = 8'd0;
   logic       r;
   logic       g;
   logic       b;
   logic [2:0] phase;

   int total = 0;
   int bad = 0;

   int m_pwm;
   int m_pre;
   int m_ramp;
   int m_ph;
   int m_dr;
   int m_dg;
   int m_db;

   logic [5:0] q[$];

   rgb_wheel_pwm #(
      .STEP_CYCLES(STEP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .brightness(brightness),
      .r(r),
      .g(g),
      .b(b),
      .phase(phase)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end
   endtask

   // colour table of the hue wheel: returns {R,G,B}
   function automatic logic [23:0] wheel(input int ph, input int rp);
      int lr;
      int lg;
      int lb;
      case (ph)
         1: begin lr = 255 - rp; lg = 255;      lb = 0;        end
         2: begin lr = 0;        lg = 255;      lb = rp;       end
         3: begin lr = 0;        lg = 255 - rp; lb = 255;      end
         4: begin lr = rp;       lg = 0;        lb = 255;      end
         5: begin lr = 255;      lg = 0;        lb = 255 - rp; end
         default: begin lr = 255; lg = rp; lb = 0; end
      endcase
      return {8'(lr), 8'(lg), 8'(lb)};
   endfunction

   function automatic int scale(input int lvl, input int br);
      return (lvl * (br + 1)) / 256;
   endfunction

   // reference model: one update per active edge, expectation queued
   always @(posedge clk) begin
      if (rst_n) begin
         logic [23:0] lv;
         logic er;
         logic eg;
         logic eb;
         lv = wheel(m_ph, m_ramp);
         er = en && (m_pwm < m_dr);
         eg = en && (m_pwm < m_dg);
         eb = en && (m_pwm < m_db);
         if (m_pwm == 255) begin
            m_dr = scale(int'(lv[23:16]), int'(brightness));
            m_dg = scale(int'(lv[15:8]), int'(brightness));
            m_db = scale(int'(lv[7:0]), int'(brightness));
         end
         if (en) begin
            if (m_pre == STEP - 1) begin
               m_pre = 0;
               if (m_ramp == 255) begin
                  m_ramp = 0;
                  m_ph = (m_ph + 1) % 6;
               end else begin
                  m_ramp = m_ramp + 1;
               end
            end else begin
               m_pre = m_pre + 1;
            end
         end
         m_pwm = (m_pwm + 1) % 256;
         q.push_back({er, eg, eb, 3'(m_ph)});
      end
   end

   // scoreboard: compare each queued expectation on the falling edge
   always @(negedge clk) begin
      if (q.size() > 0) begin
         logic [5:0] e;
         e = q.pop_front();
         chk("sb_rgb", {29'd0, r, g, b}, {29'd0, e[5:3]});
         chk("sb_phase", {29'd0, phase}, {29'd0, e[2:0]});
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      q.delete();
      m_pwm = 0;
      m_pre = 0;
      m_ramp = 0;
      m_ph = 0;
      m_dr = 0;
      m_dg = 0;
      m_db = 0;
      #1;
      chk("rst_rgb", {29'd0, r, g, b}, 32'd0);
      chk("rst_phase", {29'd0, phase}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic count_on(input int n, output int hi);
      hi = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         hi += int'(r) + int'(g) + int'(b);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      int rh;
      bit seen;

      // reset, first periods and full wheel at full brightness
      en = 1'b1;
      brightness = 8'd255;
      do_reset();
      rh = 0;
      for (int n = 1; n <= 1023; n++) begin
         @(negedge clk);
         if (n > 256 && n <= 512) rh += int'(r);
         if (n == 512) chk("p2_r_high", rh, 255);
      end
      chk("ph_before_256", {29'd0, phase}, 32'd0);
      @(negedge clk);
      chk("ph_at_256", {29'd0, phase}, 32'd1);
      repeat (6143 - 1024) @(negedge clk);
      chk("ph_before_wrap", {29'd0, phase}, 32'd5);
      @(negedge clk);
      chk("ph_wrap", {29'd0, phase}, 32'd0);

      // scaling at brightness 127 and 0
      brightness = 8'd127;
      do_reset();
      repeat (256) @(negedge clk);
      rh = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         rh += int'(r);
      end
      chk("scale_127", rh, 127);

      brightness = 8'd0;
      do_reset();
      count_on(600, hi);
      chk("scale_0", hi, 0);

      // brightness change mid-period takes effect at the next wrap
      brightness = 8'd255;
      do_reset();
      repeat (300) @(negedge clk);
      seen = 1'b0;
      for (int i = 0; i < 512 && !seen; i++) begin
         if (m_pwm == 100) seen = 1'b1;
         else @(negedge clk);
      end
      chk("find_cnt100", {31'd0, seen}, 32'd1);
      brightness = 8'd64;
      rh = 0;
      for (int i = 0; i < 155; i++) begin
         @(negedge clk);
         rh += int'(r);
      end
      chk("old_duty", rh, 155);
      @(negedge clk);
      rh = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         rh += int'(r);
      end
      chk("new_duty", rh, 64);

      // freeze mid-P2
      brightness = 8'd255;
      do_reset();
      repeat (2560) @(negedge clk);
      chk("frz_ph_pre", {29'd0, phase}, 32'd2);
      en = 1'b0;
      count_on(1000, hi);
      chk("frz_quiet", hi, 0);
      chk("frz_ph_hold", {29'd0, phase}, 32'd2);
      en = 1'b1;
      repeat (300) @(negedge clk);

      // asynchronous reset during P4
      do_reset();
      repeat (4200) @(negedge clk);
      chk("ph_p4", {29'd0, phase}, 32'd4);
      do_reset();
      repeat (100) @(negedge clk);
      chk("ph_restart", {29'd0, phase}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
